// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the APB master arbiter slice.
//   apb_state_e : transfer sequencer states (IDLE, SETUP, ACCESS, DONE)
//   APB_ADDR_W  : default APB address width
//   APB_DATA_W  : default APB data width
//   tmo_cnt_w() : width of the ACCESS timeout counter for a given limit
// ---------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Counter must be able to hold the value TIMEOUT_CYCLES itself.
   function automatic int tmo_cnt_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
// APB bus bundle between the arbiter (master) and the peripheral fabric.
//   psel, penable, pwrite, paddr, pwdata : driven by the master
//   prdata, pready                       : driven by the slave
// Modports: master, slave.
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
   parameter int ADDR_W = apb_arb_pkg::APB_ADDR_W,
   parameter int DATA_W = apb_arb_pkg::APB_DATA_W
) ();

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: picks the first set request bit scanning
// upward from i_last+1 (modulo NUM_REQ). The pointer lives in the parent.
//   i_req   : request vector
//   i_last  : index of the previous winner
//   o_grant : one-hot grant
//   o_idx   : index of the granted requester
//   o_valid : at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   always_comb begin
      logic found;
      int   cand;
      found   = 1'b0;
      cand    = 0;
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      // k = NUM_REQ wraps back to the previous winner, so it is considered last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(i_last) + k) % NUM_REQ;
         if (!found && i_req[cand]) begin
            found         = 1'b1;
            o_valid       = 1'b1;
            o_grant[cand] = 1'b1;
            o_idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// APB master that shares one APB bus between NUM_REQ local requesters using
// round-robin arbitration. Each granted request is run through SETUP and
// ACCESS, waits for pready, and returns read data/status with a one-cycle
// one-hot done pulse. All outputs are registered.
//
// Ports:
//   pclk, rst          : clock; asynchronous active-low reset
//   req[i]             : request, held until done[i]
//   req_write[i]       : direction (1 = write)
//   req_addr/req_wdata : packed per-requester address / write data
//   done[i]            : one-cycle completion pulse
//   rsp_rdata, rsp_err : response, valid while done is high, held after
//   apb                : APB master bus (psel/penable/pwrite/paddr/pwdata,
//                        prdata/pready)
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS that has stalled
// for TIMEOUT_CYCLES cycles (done with rsp_err=1, rsp_rdata=0). Without it
// ACCESS waits indefinitely and rsp_err is always 0.
// ---------------------------------------------------------------------------
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      pclk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   apb_master_arbiter_if.master      apb
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   // Registered state and outputs
   apb_state_e          r_state;
   logic [IDX_W-1:0]    r_last;
   logic [NUM_REQ-1:0]  r_gnt;
   logic                r_psel;
   logic                r_penable;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic [NUM_REQ-1:0]  r_done;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;

   // Next-state values
   apb_state_e          w_state_nxt;
   logic [IDX_W-1:0]    w_last_nxt;
   logic [NUM_REQ-1:0]  w_gnt_nxt;
   logic                w_psel_nxt;
   logic                w_penable_nxt;
   logic                w_pwrite_nxt;
   logic [ADDR_W-1:0]   w_paddr_nxt;
   logic [DATA_W-1:0]   w_pwdata_nxt;
   logic [NUM_REQ-1:0]  w_done_nxt;
   logic [DATA_W-1:0]   w_rdata_nxt;
   logic                w_err_nxt;

   // Arbiter result
   logic [NUM_REQ-1:0]  w_gnt;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic                w_any;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYCLES);
   logic [TMO_W-1:0]    r_tmo;
   logic [TMO_W-1:0]    w_tmo_nxt;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req   (req),
      .i_last  (r_last),
      .o_grant (w_gnt),
      .o_idx   (w_gnt_idx),
      .o_valid (w_any)
   );

   assign w_sel_addr  = req_addr [int'(w_gnt_idx)*ADDR_W +: ADDR_W];
   assign w_sel_wdata = req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];

   always_comb begin
      w_state_nxt   = r_state;
      w_last_nxt    = r_last;
      w_gnt_nxt     = r_gnt;
      w_psel_nxt    = r_psel;
      w_penable_nxt = r_penable;
      w_pwrite_nxt  = r_pwrite;
      w_paddr_nxt   = r_paddr;
      w_pwdata_nxt  = r_pwdata;
      w_done_nxt    = '0;
      w_rdata_nxt   = r_rdata;
      w_err_nxt     = r_err;
`ifdef APB_TIMEOUT_EN
      w_tmo_nxt     = r_tmo;
`endif
      case (r_state)
         IDLE: begin
            // Request fields are sampled only here; later changes do not
            // affect the transfer in flight.
            if (w_any) begin
               w_gnt_nxt     = w_gnt;
               w_last_nxt    = w_gnt_idx;
               w_pwrite_nxt  = req_write[w_gnt_idx];
               w_paddr_nxt   = w_sel_addr;
               w_pwdata_nxt  = w_sel_wdata;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_state_nxt   = SETUP;
            end else begin
               w_psel_nxt    = 1'b0;
            end
         end
         SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = ACCESS;
`ifdef APB_TIMEOUT_EN
            w_tmo_nxt     = '0;
`endif
         end
         ACCESS: begin
            // pready has priority over a timeout in the same cycle.
            if (apb.pready) begin
               w_rdata_nxt   = r_pwrite ? '0 : apb.prdata;
               w_err_nxt     = 1'b0;
               w_done_nxt    = r_gnt;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_state_nxt   = DONE;
            end
`ifdef APB_TIMEOUT_EN
            // This stalled cycle is the TIMEOUT_CYCLES-th one.
            else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               w_rdata_nxt   = '0;
               w_err_nxt     = 1'b1;
               w_done_nxt    = r_gnt;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_state_nxt   = DONE;
            end else begin
               w_tmo_nxt     = r_tmo + 1'b1;
            end
`endif
         end
         DONE: begin
            // done drops here; the response stays until the next completion.
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_last    <= IDX_W'(NUM_REQ - 1);
         r_gnt     <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_done    <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
         r_tmo     <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_last    <= w_last_nxt;
         r_gnt     <= w_gnt_nxt;
         r_psel    <= w_psel_nxt;
         r_penable <= w_penable_nxt;
         r_pwrite  <= w_pwrite_nxt;
         r_paddr   <= w_paddr_nxt;
         r_pwdata  <= w_pwdata_nxt;
         r_done    <= w_done_nxt;
         r_rdata   <= w_rdata_nxt;
         r_err     <= w_err_nxt;
`ifdef APB_TIMEOUT_EN
         r_tmo     <= w_tmo_nxt;
`endif
      end
   end

   assign apb.psel    = r_psel;
   assign apb.penable = r_penable;
   assign apb.pwrite  = r_pwrite;
   assign apb.paddr   = r_paddr;
   assign apb.pwdata  = r_pwdata;
   assign done        = r_done;
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter with a small four-word register
// slave (word index paddr[3:2]) whose pready can be delayed or held low.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

   localparam int NR  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic              pclk = 1'b0;
   logic              rst  = 1'b0;
   logic [NR-1:0]     req       = '0;
   logic [NR-1:0]     req_write = '0;
   logic [NR*AW-1:0]  req_addr  = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     done;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;

   bit                stall       = 1'b0;
   int                wait_states = 0;
   int                acc_cnt     = 0;
   logic [31:0]       mem [4]     = '{32'h0, 32'h0, 32'h0, 32'h0};

   int                n_pass  = 0;
   int                n_total = 0;

   apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_apb ();

   apb_master_arbiter #(
      .NUM_REQ        (NR),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .pclk      (pclk),
      .rst       (rst),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .apb       (u_apb)
   );

   always #5 pclk = ~pclk;

   // Slave: pready is independent of phase so the DUT must ignore it
   // outside ACCESS.
   assign u_apb.pready = !stall && (acc_cnt >= wait_states);
   assign u_apb.prdata = mem[u_apb.paddr[3:2]];

   always @(posedge pclk) begin
      if (u_apb.psel && u_apb.penable && !u_apb.pready) acc_cnt <= acc_cnt + 1;
      else                                              acc_cnt <= 0;
      if (u_apb.psel && u_apb.penable && u_apb.pready && u_apb.pwrite)
         mem[u_apb.paddr[3:2]] <= u_apb.pwdata;
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_write[i]         = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic wait_done(output logic [NR-1:0] d, output int cyc);
      d   = '0;
      cyc = 0;
      while (cyc < 40 && d == '0) begin
         tick();
         cyc++;
         d = done;
      end
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      n_total++; if (u_apb.psel !== 1'b0)    $display("FAIL rst_psel got %b want 0", u_apb.psel); else n_pass++;
      n_total++; if (u_apb.penable !== 1'b0) $display("FAIL rst_penable got %b want 0", u_apb.penable); else n_pass++;
      n_total++; if (u_apb.pwrite !== 1'b0)  $display("FAIL rst_pwrite got %b want 0", u_apb.pwrite); else n_pass++;
      n_total++; if (u_apb.paddr !== '0)     $display("FAIL rst_paddr got %h want 0", u_apb.paddr); else n_pass++;
      n_total++; if (u_apb.pwdata !== '0)    $display("FAIL rst_pwdata got %h want 0", u_apb.pwdata); else n_pass++;
      n_total++; if (done !== '0)            $display("FAIL rst_done got %b want 0000", done); else n_pass++;
      n_total++; if (rsp_rdata !== '0)       $display("FAIL rst_rdata got %h want 0", rsp_rdata); else n_pass++;
      n_total++; if (rsp_err !== 1'b0)       $display("FAIL rst_err got %b want 0", rsp_err); else n_pass++;
      rst = 1'b1;
      tick();
      n_total++; if (u_apb.psel !== 1'b0)    $display("FAIL idle_psel got %b want 0", u_apb.psel); else n_pass++;
   endtask

   task automatic test_single_write();
      set_req(0, 1'b1, 32'h0, 32'hDEADBEEF);
      req[0] = 1'b1;                                    // cycle 0 (IDLE)
      tick();                                           // cycle 1 (SETUP)
      n_total++; if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b0) $display("FAIL wr_setup got psel=%b penable=%b want 1/0", u_apb.psel, u_apb.penable); else n_pass++;
      n_total++; if (u_apb.paddr !== 32'h0 || u_apb.pwrite !== 1'b1) $display("FAIL wr_addr got %h/%b want 0/1", u_apb.paddr, u_apb.pwrite); else n_pass++;
      n_total++; if (u_apb.pwdata !== 32'hDEADBEEF) $display("FAIL wr_pwdata got %h want deadbeef", u_apb.pwdata); else n_pass++;
      tick();                                           // cycle 2 (ACCESS)
      n_total++; if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b1) $display("FAIL wr_access got psel=%b penable=%b want 1/1", u_apb.psel, u_apb.penable); else n_pass++;
      n_total++; if (done !== 4'b0000) $display("FAIL wr_early_done got %b want 0000", done); else n_pass++;
      tick();                                           // cycle 3 (DONE)
      n_total++; if (done !== 4'b0001) $display("FAIL wr_done got %b want 0001", done); else n_pass++;
      n_total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) $display("FAIL wr_rsp got err=%b data=%h want 0/0", rsp_err, rsp_rdata); else n_pass++;
      n_total++; if (u_apb.psel !== 1'b0 || u_apb.penable !== 1'b0) $display("FAIL wr_release got psel=%b penable=%b want 0/0", u_apb.psel, u_apb.penable); else n_pass++;
      req[0] = 1'b0;
      tick();                                           // cycle 4 (IDLE)
      n_total++; if (done !== 4'b0000) $display("FAIL wr_done_pulse got %b want 0000", done); else n_pass++;
   endtask

   task automatic test_read_back();
      wait_states = 2;
      set_req(1, 1'b0, 32'h0, 32'h0);
      req[1] = 1'b1;
      tick();                                           // SETUP
      n_total++; if (u_apb.pwrite !== 1'b0 || u_apb.psel !== 1'b1) $display("FAIL rd_setup got pwrite=%b psel=%b want 0/1", u_apb.pwrite, u_apb.psel); else n_pass++;
      tick();                                           // ACCESS 1
      tick();                                           // ACCESS 2
      tick();                                           // ACCESS 3
      n_total++; if (u_apb.penable !== 1'b1 || done !== 4'b0000) $display("FAIL rd_wait got penable=%b done=%b want 1/0000", u_apb.penable, done); else n_pass++;
      tick();                                           // DONE
      n_total++; if (done !== 4'b0010) $display("FAIL rd_done got %b want 0010", done); else n_pass++;
      n_total++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rsp_rdata); else n_pass++;
      req[1] = 1'b0;
      tick();
      n_total++; if (done !== 4'b0000 || rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_hold got done=%b data=%h want 0000/deadbeef", done, rsp_rdata); else n_pass++;
      wait_states = 0;
   endtask

   task automatic test_fairness();
      logic [NR-1:0] d;
      int            cyc;
      int            order [5] = '{0, 1, 2, 3, 0};
      int            lat   [5] = '{3, 4, 4, 4, 4};
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'(i * 4), 32'h0);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_done(d, cyc);
         n_total++; if (d !== 4'(1 << order[k])) $display("FAIL rr_order%0d got %b want %b", k, d, 4'(1 << order[k])); else n_pass++;
         n_total++; if (cyc != lat[k]) $display("FAIL rr_latency%0d got %0d want %0d", k, cyc, lat[k]); else n_pass++;
         // Requester 0 keeps its request up after its first grant.
         if (k != 0) req[order[k]] = 1'b0;
      end
   endtask

   task automatic test_stability();
      tick();
      stall = 1'b1;
      set_req(0, 1'b1, 32'h10, 32'h12345678);
      req[0] = 1'b1;
      tick();                                           // SETUP
      tick();                                           // ACCESS, stalled
      set_req(0, 1'b1, 32'h20, 32'hFFFF0000);
      req[0] = 1'b0;
      tick();
      tick();
      tick();
      n_total++; if (u_apb.paddr !== 32'h10) $display("FAIL stab_paddr got %h want 10", u_apb.paddr); else n_pass++;
      n_total++; if (u_apb.pwdata !== 32'h12345678) $display("FAIL stab_pwdata got %h want 12345678", u_apb.pwdata); else n_pass++;
      n_total++; if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b1 || done !== 4'b0000) $display("FAIL stab_hold got psel=%b penable=%b done=%b want 1/1/0000", u_apb.psel, u_apb.penable, done); else n_pass++;
      stall = 1'b0;
      tick();
      n_total++; if (done !== 4'b0001) $display("FAIL stab_done got %b want 0001", done); else n_pass++;
      n_total++; if (rsp_rdata !== 32'h0) $display("FAIL stab_wr_rdata got %h want 0", rsp_rdata); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] d;
      int            cyc;
      tick();
      stall = 1'b1;
      set_req(2, 1'b0, 32'h8, 32'h0);
      req[2] = 1'b1;
      tick();                                           // SETUP
      tick();                                           // ACCESS
      n_total++; if (u_apb.penable !== 1'b1) $display("FAIL mrst_pre got penable=%b want 1", u_apb.penable); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (u_apb.psel !== 1'b0 || u_apb.penable !== 1'b0 || done !== 4'b0000) $display("FAIL mrst_async got psel=%b penable=%b done=%b want 0/0/0000", u_apb.psel, u_apb.penable, done); else n_pass++;
      req   = '0;
      stall = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      n_total++; if (done !== 4'b0000 || u_apb.psel !== 1'b0) $display("FAIL mrst_quiet got done=%b psel=%b want 0000/0", done, u_apb.psel); else n_pass++;
      // Without the pointer reset, requester 3 would be next after 2.
      set_req(1, 1'b0, 32'h0, 32'h0);
      set_req(3, 1'b0, 32'h0, 32'h0);
      req = 4'b1010;
      wait_done(d, cyc);
      n_total++; if (d !== 4'b0010) $display("FAIL mrst_first got %b want 0010", d); else n_pass++;
      n_total++; if (rsp_rdata !== 32'h12345678) $display("FAIL mrst_rdata got %h want 12345678", rsp_rdata); else n_pass++;
      req[1] = 1'b0;
      wait_done(d, cyc);
      n_total++; if (d !== 4'b1000) $display("FAIL mrst_second got %b want 1000", d); else n_pass++;
      req[3] = 1'b0;
   endtask

   task automatic test_long_stall();
      logic [NR-1:0] d;
      int            n_acc;
      tick();
      stall = 1'b1;
      set_req(3, 1'b0, 32'h0, 32'h0);
      req[3] = 1'b1;
      tick();                                           // SETUP
      d     = '0;
      n_acc = 0;
`ifdef APB_TIMEOUT_EN
      while (n_acc < 40 && d == '0) begin
         tick();
         d = done;
         if (u_apb.psel && u_apb.penable) n_acc++;
      end
      n_total++; if (d !== 4'b1000) $display("FAIL tmo_done got %b want 1000", d); else n_pass++;
      n_total++; if (n_acc != TMO) $display("FAIL tmo_cycles got %0d want %0d", n_acc, TMO); else n_pass++;
      n_total++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL tmo_rsp got err=%b data=%h want 1/0", rsp_err, rsp_rdata); else n_pass++;
      n_total++; if (u_apb.psel !== 1'b0) $display("FAIL tmo_psel got %b want 0", u_apb.psel); else n_pass++;
      req[3] = 1'b0;
      stall  = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done != '0) d = done;
         if (u_apb.psel && u_apb.penable) n_acc++;
      end
      n_total++; if (d !== 4'b0000) $display("FAIL stall_no_done got %b want 0000", d); else n_pass++;
      n_total++; if (n_acc != 20) $display("FAIL stall_access got %0d want 20", n_acc); else n_pass++;
      stall = 1'b0;
      tick();
      n_total++; if (done !== 4'b1000) $display("FAIL stall_done got %b want 1000", done); else n_pass++;
      n_total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) $display("FAIL stall_rsp got err=%b data=%h want 0/12345678", rsp_err, rsp_rdata); else n_pass++;
      req[3] = 1'b0;
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_back();
      test_fairness();
      test_stability();
      test_reset_mid();
      test_long_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master controller that shares one APB bus, and the GPIO register slave on it, between NUM_REQ local requesters.
- Round-robin arbitration over the requesters.
- Sequences each granted request through the APB SETUP and ACCESS phases, waits for pready, then returns read data and status to the winning requester.
- Sits between core-side requesters and the APB peripheral fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  APB clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held until its done pulse.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid while done is high.
- rsp_err  out  1  error flag, valid while done is high.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - state=IDLE.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, grant the first set bit scanning from last+1 modulo NUM_REQ.
  - Latch its write/addr/wdata into paddr/pwrite/pwdata.
  - Set psel=1, penable=0, last=grant; go to SETUP.
  - If no req is set, stay in IDLE with psel=0.
- SETUP: penable<=1; go to ACCESS. Exactly one cycle.
- ACCESS:
  - psel=1 and penable=1 held; paddr/pwrite/pwdata stable.
  - If pready=1, capture rsp_rdata<=prdata for reads (0 for writes), rsp_err<=0, done[grant]<=1, psel/penable<=0; go to DONE.
  - If pready=0, stay in ACCESS.
- DONE:
  - done held for this single cycle; req is ignored during this cycle.
  - Next cycle: done<=0, rsp_rdata/rsp_err hold until the next completion; go to IDLE.
- Requester rule: drop req, or change its fields, in the cycle after done is seen. A requester that keeps req high gets re-arbitrated fairly behind the others.
- Latency with zero-wait slave (pready=1 in first ACCESS cycle): req seen in IDLE at cycle 0, SETUP at 1, ACCESS at 2, done at 3, IDLE at 4. Each wait state adds 1 cycle.
- Simultaneous requests: exactly one is granted per transaction; no requester waits more than NUM_REQ-1 transactions.
- A req deasserted mid-transaction does not abort it; completion still pulses done.
- req fields are sampled only in IDLE; later changes are ignored for the current transfer.
- Reset mid-transfer returns all outputs to 0 immediately. No done is issued for the aborted transfer.
- pready outside ACCESS is ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES: force psel/penable<=0, rsp_rdata<=0, rsp_err<=1, done[grant]<=1; go to DONE.
  - pready arriving in the same cycle as the timeout wins, giving a normal completion.
- Not defined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

Decomposition:
- Package apb_arb_pkg:
  - state enum type (IDLE, SETUP, ACCESS, DONE).
  - Default width constants ADDR_W/DATA_W.
  - Timeout counter width derived from TIMEOUT_CYCLES.
- Sub-module rr_arbiter (natural split):
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant and its index.
  - Combinational priority rotation; pointer kept in the parent.

Test Plan:
1. Single write: req[0]=1, addr=0x0, wdata=0xDEADBEEF, write, pready=1 in first ACCESS -> psel at cycle 1, penable at cycle 2, done[0] at cycle 3, rsp_err=0.
2. Read-back: req[1] read of addr 0x0 from the GPIO slave, pready after 2 waits -> ACCESS lasts 3 cycles; done[1] carries rsp_rdata=0xDEADBEEF.
3. Fairness: req=4'b1111 held, each requester dropping req after its done -> grant order 0,1,2,3; with requester 0 re-asserting, order 0,1,2,3,0.
4. Stability: change req_addr[0] while ACCESS is stalled -> paddr stays at the latched value until done.
5. Reset mid-ACCESS: rst=0 for 1 cycle -> psel/penable/done immediately 0; next req starts at requester 0.
6. APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> done pulses after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0; psel is 0 in DONE.
